// File: rtl/bicubic_sched.sv
// Bicubic upscaler sequencer: walks the target frame, fetches 4x4 source windows, and writes kernel results.
// Optional build macro BICUBIC_EXACT_SKIP_EN bypasses the kernel for phase-aligned pixels.
module bicubic_sched #(
  parameter int IMG_W  = 100,
  parameter int ROM_AW = 14,
  parameter int RES_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [6:0]        H0,
  input  logic [6:0]        V0,
  input  logic [4:0]        SW,
  input  logic [4:0]        SH,
  input  logic [5:0]        TW,
  input  logic [5:0]        TH,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  input  logic              k_ready,
  output logic              tap_valid,
  output logic [7:0]        tap_data,
  output logic [3:0]        tap_idx,
  output logic [5:0]        frac_x,
  output logic [5:0]        frac_y,
  input  logic              k_res_valid,
  input  logic [7:0]        k_res,
  output logic              sram_wen,
  output logic [RES_AW-1:0] sram_addr,
  output logic [7:0]        sram_d,
  output logic              DONE
);

`ifdef BICUBIC_EXACT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAITK, S_FETCH, S_WAITR, S_WRITE, S_FIN
  } state_t;

  state_t            state;
  logic [6:0]        h0, v0;
  logic [4:0]        sw, sh;
  logic [5:0]        tw, th;
  logic [5:0]        tx, ty;
  logic [6:0]        ix, iy, accx, accy;
  logic [RES_AW-1:0] res_addr;
  logic [3:0]        tap_n;
  logic              skip_q, sram_wen_q, tap_valid_q;
  logic [7:0]        sram_d_q;

  // Neighbour coordinate base-1+d saturated to the image; signed so the -1 underflow is visible.
  function automatic logic [6:0] clamp_c(input logic [6:0] base, input logic [1:0] d);
    logic signed [7:0] v;
    v = $signed({1'b0, base}) + $signed({6'd0, d}) - 8'sd1;
    if (v < 8'sd0)                       clamp_c = '0;
    else if (v > $signed(8'(IMG_W - 1))) clamp_c = 7'(IMG_W - 1);
    else                                 clamp_c = v[6:0];
  endfunction

  function automatic logic [ROM_AW-1:0] tap_addr(input logic [6:0] cx, input logic [6:0] cy,
                                                 input logic [3:0] k);
    tap_addr = ROM_AW'(clamp_c(cy, k[3:2])) * ROM_AW'(IMG_W) + ROM_AW'(clamp_c(cx, k[1:0]));
  endfunction

  logic [6:0] xstep, ystep, accx_n, accy_n, ix_n, iy_n;
  logic       skip_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    xstep  = (tw == 6'd1) ? 7'd0 : {2'b00, sw - 5'd1};
    ystep  = (th == 6'd1) ? 7'd0 : {2'b00, sh - 5'd1};
    accx_n = accx;
    accy_n = accy;
    ix_n   = ix;
    iy_n   = iy;
    // Accumulators stay below 2*(T-1), so one conditional subtract completes the DDA step.
    if (tw != 6'd1 && accx >= {1'b0, tw - 6'd1}) begin
      accx_n = accx - {1'b0, tw - 6'd1};
      ix_n   = ix + 7'd1;
    end
    if (th != 6'd1 && accy >= {1'b0, th - 6'd1}) begin
      accy_n = accy - {1'b0, th - 6'd1};
      iy_n   = iy + 7'd1;
    end
    skip_n = SKIP_EN && (accx_n == 7'd0) && (accy_n == 7'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      {h0, v0}    <= '0;
      {sw, sh}    <= '0;
      {tw, th}    <= '0;
      {tx, ty}    <= '0;
      {ix, iy}    <= '0;
      {accx, accy}<= '0;
      res_addr    <= '0;
      tap_n       <= '0;
      skip_q      <= 1'b0;
      rom_ce      <= 1'b0;
      rom_addr    <= '0;
      tap_valid_q <= 1'b0;
      tap_idx     <= '0;
      frac_x      <= '0;
      frac_y      <= '0;
      sram_wen_q  <= 1'b0;
      sram_addr   <= '0;
      sram_d_q    <= '0;
      DONE        <= 1'b0;
    end else begin
      tap_valid_q <= rom_ce & ~skip_q;
      tap_idx     <= tap_n;
      sram_wen_q  <= 1'b0;
      case (state)
        S_IDLE, S_FIN: if (start) begin
          {h0, v0, sw, sh, tw, th} <= {H0, V0, SW, SH, TW, TH};
          {tx, ty}     <= '0;
          {accx, accy} <= '0;
          ix           <= H0;
          iy           <= V0;
          res_addr     <= '0;
          DONE         <= 1'b0;
          state        <= S_SETUP;
        end
        S_SETUP: begin
          {accx, accy} <= {accx_n, accy_n};
          {ix, iy}     <= {ix_n, iy_n};
          frac_x       <= accx_n[5:0];
          frac_y       <= accy_n[5:0];
          skip_q       <= skip_n;
          if (skip_n) begin
            rom_ce   <= 1'b1;
            rom_addr <= tap_addr(ix_n, iy_n, 4'd5);
            state    <= S_FETCH;
          end else begin
            state    <= S_WAITK;
          end
        end
        S_WAITK: if (k_ready) begin
          rom_ce   <= 1'b1;
          rom_addr <= tap_addr(ix, iy, 4'd0);
          tap_n    <= 4'd0;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          if (skip_q) begin
            rom_ce     <= 1'b0;
            sram_wen_q <= 1'b1;
            sram_addr  <= res_addr;
            state      <= S_WRITE;
          end else if (tap_n == 4'd15) begin
            rom_ce <= 1'b0;
            state  <= S_WAITR;
          end else begin
            tap_n    <= tap_n + 4'd1;
            rom_addr <= tap_addr(ix, iy, tap_n + 4'd1);
          end
        end
        S_WAITR: if (k_res_valid) begin
          sram_wen_q <= 1'b1;
          sram_addr  <= res_addr;
          sram_d_q   <= k_res;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          res_addr <= res_addr + 1'b1;
          if (tx == tw - 6'd1) begin
            tx   <= '0;
            accx <= '0;
            ix   <= h0;
            ty   <= ty + 6'd1;
            accy <= accy + ystep;
            if (ty == th - 6'd1) begin
              DONE  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_SETUP;
            end
          end else begin
            tx    <= tx + 6'd1;
            accx  <= accx + xstep;
            state <= S_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tap_valid = tap_valid_q;
  assign tap_data  = tap_valid_q ? rom_q : 8'd0;
  assign sram_wen  = sram_wen_q;
  // The bypass path writes the ROM word the same cycle it arrives.
  assign sram_d    = (skip_q && sram_wen_q) ? rom_q : sram_d_q;

endmodule

// File: doc/bicubic_sched.md
Name: bicubic_sched

Overview:
- Top-level sequencer for the Bicubic upscaler.
- On start it walks every target pixel of the TW x TH output in raster order and maps each one to a source position inside the ROI (H0, V0, SW, SH) of the 100x100 ImgROM.
- For each target pixel it fetches the 4x4 source neighbourhood, streams the 16 taps plus fractional phase to the interpolation kernel, and writes the kernel result to ResultSRAM at address ty*TW+tx.
- Raises DONE when the whole frame has been written.

Parameters:
- IMG_W, 100, source image width/height in pixels (ROM address = y*IMG_W + x)
- ROM_AW, 14, ImgROM address width
- RES_AW, 12, ResultSRAM address width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame start request; sampled only in IDLE/DONE
- H0  in  7  ROI origin x; captured on accepted start
- V0  in  7  ROI origin y; captured on accepted start
- SW  in  5  ROI width; captured on accepted start
- SH  in  5  ROI height; captured on accepted start
- TW  in  6  target width; captured on accepted start
- TH  in  6  target height; captured on accepted start
- rom_ce  out  1  ImgROM read enable
- rom_addr  out  ROM_AW  ImgROM address
- rom_q  in  8  ImgROM data, valid one cycle after rom_ce
- k_ready  in  1  kernel idle, can accept a new window
- tap_valid  out  1  tap_data is a valid tap
- tap_data  out  8  tap pixel
- tap_idx  out  4  tap index, dy*4+dx
- frac_x  out  6  x phase numerator; denominator is TW-1
- frac_y  out  6  y phase numerator; denominator is TH-1
- k_res_valid  in  1  kernel result valid, one-cycle pulse
- k_res  in  8  kernel result, already rounded and clipped
- sram_wen  out  1  ResultSRAM write strobe
- sram_addr  out  RES_AW  ResultSRAM address
- sram_d  out  8  ResultSRAM write data
- DONE  out  1  frame complete; level

Behaviour:
- Reset (RST low, any state, including mid-frame): go to IDLE; all outputs 0; counters and accumulators cleared; no partial write completes. Kernel is expected to be reset from the same RST.
- States: IDLE -> SETUP -> WAITK -> FETCH -> WAITR -> WRITE -> (SETUP | FIN).
  - IDLE/FIN: start=1 -> capture config, tx=ty=0, clear DONE, go to SETUP. start in any other state is ignored.
- SETUP (1 cycle), DDA per axis, x shown (y identical with SH/TH):
  - accx advances by (SW-1) per tx step; while accx >= TW-1, subtract TW-1 and ix++.
  - ix starts at H0; frac_x = accx.
  - TW==1: step is 0, ix = H0, frac_x = 0 for the whole row.
  - Row advance resets accx=0 and ix=H0, then steps the y DDA.
- WAITK: hold until k_ready=1, then FETCH.
- FETCH (16 consecutive cycles):
  - rom_ce=1 with rom_addr = clamp(iy-1+dy)*IMG_W + clamp(ix-1+dx).
  - Order: dy 0..3 outer, dx 0..3 inner. clamp() saturates to [0, IMG_W-1].
  - tap_valid/tap_data/tap_idx follow rom_ce by exactly 1 cycle: 16 back-to-back taps, no gaps, no stall.
  - frac_x/frac_y stable from SETUP until WRITE.
- WAITR: wait for k_res_valid. sram_wen must not assert before it.
- WRITE (1 cycle): sram_wen=1, sram_addr = ty*TW+tx (running counter, no multiplier), sram_d = k_res.
  - Then advance tx; on tx==TW-1 wrap tx=0 and ty++.
  - Last pixel (tx==TW-1 and ty==TH-1) -> FIN.
- FIN: DONE=1, held until the next accepted start; DONE clears the cycle after that start.
- Throughput: 19 + kernel latency cycles per pixel.
- All arithmetic is unsigned.
  - Accumulators are 7 bits, bounded below 2*(TW-1).
  - Clamp is computed on 8-bit signed intermediates.

Optional Feature:
- Macro: BICUBIC_EXACT_SKIP_EN
- Defined: when frac_x==0 and frac_y==0, FETCH issues one read only, at the centre address iy*IMG_W+ix. The kernel is bypassed: no tap_valid and no k_ready wait. WRITE stores rom_q directly. Per-pixel cost is 3 cycles.
- Undefined: every pixel takes the full 16-tap kernel path.
- SRAM contents are identical either way.

Test Plan:
- H0=10 V0=20 SW=4 SH=4 TW=7 TH=7, pixel (0,0):
  - rom_addr sequence is 1909,1910,1911,1912,2009 … 2212.
  - frac_x=frac_y=0.
  - Pixel (1,0): ix=10, frac_x=3.
  - 49 sram writes to addresses 0..48 in order, then DONE=1.
- Border: H0=0 V0=0 SW=4 TW=4, pixel (0,0):
  - Row 0 addresses are 0,0,1,2; tap row 0 equals tap row 1 (clamp).
  - H0=96 SW=4, tx=3: columns 98,99,99,99.
- Handshake: hold k_ready=0 for 20 cycles in WAITK -> rom_ce stays 0. Delay k_res_valid by 7 cycles -> a single sram_wen in the cycle after the pulse.
- start pulsed mid-frame -> ignored, config unchanged. After DONE, a second start -> DONE drops next cycle, frame reruns.
- RST low during FETCH tap 8 -> all outputs 0 immediately. After release plus start, the frame restarts from address 0 with no stale write.
- BICUBIC_EXACT_SKIP_EN, TW=SW=TH=SH=4:
  - Each pixel issues one rom_ce and no tap_valid.
  - SRAM equals the ROI pixels.
  - 16 pixels finish in about 48 cycles.
